// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand select for the RV32I core.
// Latches decoded operands, forwards results from EX/MEM and MEM/WB, and
// inserts a NOP bubble (alu_op = 4'b1111) on load-use hazards, flush or an
// invalid decode slot.
//
// Build option: define FORWARDING_EN to enable the bypass network. Without it
// the bypass inputs are ignored and load_use_stall becomes a full RAW
// interlock against any register-writing instruction sitting in EX.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alu_op,
    input  logic            id_alu_src_a,
    input  logic            id_alu_src_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_alu_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] src_A,
    output logic [XLEN-1:0] src_B,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            load_use_stall
);

    localparam logic [3:0] ALU_NOP = 4'b1111;

    // Everything the EX stage needs from decode, held as one register.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            src_a_sel;
        logic            src_b_sel;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            valid;
    } ex_state_t;

    // Reset and bubble share one encoding: no side effects, NOP opcode.
    localparam ex_state_t BUBBLE = '{
        pc:        '0,
        rs1_data:  '0,
        rs2_data:  '0,
        imm:       '0,
        rs1:       '0,
        rs2:       '0,
        rd:        '0,
        alu_op:    ALU_NOP,
        src_a_sel: 1'b0,
        src_b_sel: 1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        valid:     1'b0
    };

    ex_state_t       st_q, st_d;
    logic            ex_hazard_src;
    logic            rs_match;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // EX instruction whose result is not yet available to the ID instruction.
`ifdef FORWARDING_EN
    assign ex_hazard_src = st_q.valid & st_q.mem_read;
`else
    assign ex_hazard_src = st_q.valid & (st_q.mem_read | st_q.reg_write);
`endif

    assign rs_match       = (st_q.rd == id_rs1) | (st_q.rd == id_rs2);
    assign load_use_stall = ex_hazard_src & (st_q.rd != 5'd0) & id_valid & rs_match;

`ifdef FORWARDING_EN
    // Youngest producer first: EX/MEM beats MEM/WB; x0 is never bypassed.
    function automatic logic [XLEN-1:0] bypass(input logic [4:0]      rs,
                                               input logic [XLEN-1:0] reg_data);
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs)
            return exmem_alu_result;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs)
            return memwb_data;
        else
            return reg_data;
    endfunction

    // Per-operand bypass mux on the registered source indices.
    always_comb begin
        fwd_rs1 = bypass(st_q.rs1, st_q.rs1_data);
        fwd_rs2 = bypass(st_q.rs2, st_q.rs2_data);
    end
`else
    logic unused_bypass;

    // No bypass network: operands come straight from the latched regfile data.
    always_comb begin
        fwd_rs1 = st_q.rs1_data;
        fwd_rs2 = st_q.rs2_data;
    end

    // Bypass ports and source indices stay in the port list but feed nothing.
    assign unused_bypass = ^{exmem_rd, exmem_reg_write, exmem_alu_result,
                             memwb_rd, memwb_reg_write, memwb_data,
                             st_q.rs1, st_q.rs2};
`endif

    // Next-state selection: flush > stall > hazard/invalid bubble > capture.
    always_comb begin
        st_d = st_q;
        if (flush) begin
            st_d = BUBBLE;
        end else if (stall) begin
            st_d = st_q;
        end else if (load_use_stall || !id_valid) begin
            st_d = BUBBLE;
        end else begin
            st_d.pc        = id_pc;
            st_d.rs1_data  = id_rs1_data;
            st_d.rs2_data  = id_rs2_data;
            st_d.imm       = id_imm;
            st_d.rs1       = id_rs1;
            st_d.rs2       = id_rs2;
            st_d.rd        = id_rd;
            st_d.alu_op    = id_alu_op;
            st_d.src_a_sel = id_alu_src_a;
            st_d.src_b_sel = id_alu_src_b;
            st_d.reg_write = id_reg_write;
            st_d.mem_read  = id_mem_read;
            st_d.mem_write = id_mem_write;
            st_d.valid     = id_valid;
        end
    end

    // Stage register with synchronous active-low reset overriding everything.
    always_ff @(posedge clk) begin
        if (!reset_n)
            st_q <= BUBBLE;
        else
            st_q <= st_d;
    end

    assign src_A         = st_q.src_a_sel ? st_q.pc  : fwd_rs1;
    assign src_B         = st_q.src_b_sel ? st_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_op        = st_q.alu_op;
    assign ex_pc         = st_q.pc;
    assign ex_rd         = st_q.rd;
    assign ex_valid      = st_q.valid;
    assign ex_reg_write  = st_q.reg_write;
    assign ex_mem_read   = st_q.mem_read;
    assign ex_mem_write  = st_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage; expectations follow FORWARDING_EN.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n, stall, flush, id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [3:0]      id_alu_op;
    logic            id_alu_src_a, id_alu_src_b;
    logic            id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]      exmem_rd, memwb_rd;
    logic            exmem_reg_write, memwb_reg_write;
    logic [XLEN-1:0] exmem_alu_result, memwb_data;
    logic [XLEN-1:0] src_A, src_B, ex_pc, ex_store_data;
    logic [3:0]      alu_op;
    logic [4:0]      ex_rd;
    logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .exmem_rd(exmem_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_alu_result(exmem_alu_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .memwb_data(memwb_data), .src_A(src_A), .src_B(src_B), .alu_op(alu_op),
        .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one decoded instruction on the ID inputs.
    task automatic id_set(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                          input logic [3:0] op, input logic sa, input logic sb,
                          input logic [31:0] imm, input logic rw, input logic mr);
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1;
        id_rs2 = rs2; id_rs2_data = d2; id_rd = rd; id_alu_op = op;
        id_alu_src_a = sa; id_alu_src_b = sb; id_imm = imm;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    endtask

    initial begin
        reset_n = 0; stall = 1; flush = 0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_alu_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_data = 0;

        // Reset wins over stall.
        tick(); tick();
        chk("rst_alu_op", alu_op, 4'hF);
        chk("rst_valid", ex_valid, 0);
        chk("rst_src_A", src_A, 0);
        chk("rst_src_B", src_B, 0);
        chk("rst_lus", load_use_stall, 0);
        chk("rst_pc_rd", {ex_pc[26:0], ex_rd}, 0);

        // Plain issue.
        reset_n = 1; stall = 0;
        id_set(32'h100, 1, 1000, 2, 2000, 10, 4'h0, 0, 0, 0, 1, 0);
        tick();
        chk("plain_src_A", src_A, 1000);
        chk("plain_src_B", src_B, 2000);
        chk("plain_alu_op", alu_op, 4'h0);
        chk("plain_ctl", {ex_valid, ex_reg_write, ex_mem_read, ex_rd}, {3'b110, 5'd10});
        chk("plain_pc", ex_pc, 32'h100);

        // Forwarding priority on rs1.
        id_set(32'h104, 5, 1, 6, 2, 11, 4'h1, 0, 0, 0, 1, 0);
        tick();
        exmem_rd = 5; exmem_reg_write = 1; exmem_alu_result = 32'hDEAD_BEEF;
        memwb_rd = 5; memwb_reg_write = 1; memwb_data = 32'hCAFE_BEBE;
        #1;
        chk("fwd_exmem", src_A, FWD ? 32'hDEAD_BEEF : 32'd1);
        chk("fwd_rs2_none", ex_store_data, 2);
        exmem_rd = 0;
        #1;
        chk("fwd_memwb", src_A, FWD ? 32'hCAFE_BEBE : 32'd1);

        // x0 never forwarded; immediate and PC select.
        exmem_reg_write = 0; memwb_rd = 0; memwb_reg_write = 1; memwb_data = 7;
        id_set(32'h200, 7, 32'h33, 0, 0, 12, 4'h2, 1, 1, 32'hFFFF_F800, 1, 0);
        tick();
        chk("imm_src_B", src_B, 32'hFFFF_F800);
        chk("x0_store", ex_store_data, 0);
        chk("pc_src_A", src_A, 32'h200);
        memwb_reg_write = 0;

        // Load-use: load to x3 in EX, consumer reads x3 via rs2.
        id_set(32'h204, 8, 0, 9, 0, 3, 4'h0, 0, 1, 32'h10, 1, 1);
        tick();
        chk("ld_in_ex", {ex_mem_read, ex_rd}, {1'b1, 5'd3});
        id_set(32'h208, 4, 32'h44, 3, 32'h55, 13, 4'h5, 0, 0, 0, 1, 0);
        #1;
        chk("lus_set", load_use_stall, 1);
        tick();
        chk("lus_bubble_op", alu_op, 4'hF);
        chk("lus_bubble_vld", ex_valid, 0);
        chk("lus_clear", load_use_stall, 0);
        tick();
        chk("lus_reissue", {ex_valid, alu_op, ex_rd}, {1'b1, 4'h5, 5'd13});

        // ALU producer in EX: interlock only without forwarding.
        id_rs1 = 13; id_rs2 = 1;
        #1;
        chk("alu_raw", load_use_stall, FWD ? 1'b0 : 1'b1);
        id_valid = 0;
        #1;
        chk("raw_invalid_id", load_use_stall, 0);

        // Flush beats stall.
        id_set(32'h300, 1, 32'h11, 2, 32'h22, 14, 4'h6, 0, 0, 0, 1, 0);
        stall = 1; flush = 1;
        tick();
        chk("flush_rw", ex_reg_write, 0);
        chk("flush_op", alu_op, 4'hF);
        chk("flush_vld", ex_valid, 0);
        stall = 0; flush = 0;
        tick();
        chk("post_flush_issue", {ex_valid, ex_rd}, {1'b1, 5'd14});

        // Stall holds everything for 3 cycles while ID changes.
        stall = 1;
        id_set(32'h400, 9, 32'h99, 8, 32'h88, 15, 4'h7, 1, 1, 32'h5, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {ex_valid, ex_reg_write, ex_mem_read, alu_op, ex_rd},
                {3'b110, 4'h6, 5'd14});
            chk("stall_data", src_A + src_B + ex_pc, 32'h11 + 32'h22 + 32'h300);
        end

        // Invalid decode slot loads a bubble.
        stall = 0; id_valid = 0;
        tick();
        chk("invalid_bubble", {ex_valid, ex_reg_write, alu_op}, {2'b00, 4'hF});

        // Mid-run reset overrides stall.
        id_set(32'h500, 1, 1, 2, 2, 16, 4'h3, 0, 0, 0, 1, 0);
        tick();
        stall = 1; reset_n = 0;
        tick();
        chk("midrst", {ex_valid, ex_reg_write, alu_op, ex_rd}, {2'b00, 4'hF, 5'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
